// File: rtl/spi_page_writer.sv
// Serial-flash writer for a W25Q32: one 1024-bit page program from a bit-serial buffer,
// or one 4 KB sector erase, each preceded by Write Enable and followed by status polling.
module spi_page_writer #(
    parameter int CSH_CYCLES = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        START,
    input  logic        OPTYPE,
    input  logic [2:0]  IMGNUM,
    input  logic [11:0] PAGE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        nBUFRDEN,
    output logic [9:0]  BUFRDADDR,
    input  logic        BUFRDDATA,
    output logic        nCS,
    output logic        CLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WREN    = 4'd1;
    localparam logic [3:0] S_GAP1    = 4'd2;
    localparam logic [3:0] S_CMD     = 4'd3;
    localparam logic [3:0] S_DATA    = 4'd4;
    localparam logic [3:0] S_END_CMD = 4'd5;
    localparam logic [3:0] S_GAP2    = 4'd6;
    localparam logic [3:0] S_RDSR    = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    localparam logic [7:0]  OP_WREN  = 8'h06;
    localparam logic [7:0]  OP_PP    = 8'h02;
    localparam logic [7:0]  OP_SE    = 8'h20;
    localparam logic [7:0]  OP_RDSR  = 8'h05;
    localparam logic [7:0]  GAP_LAST = 8'(CSH_CYCLES);
    localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);

    logic [3:0]  state_q, state_d;
    logic        phase_q, phase_d;
    logic [9:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        stat_q, stat_d;
    logic [31:0] sh_q, sh_d;
    logic        op_q, op_d;
    logic [2:0]  img_q, img_d;
    logic [11:0] page_q, page_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        nbufrden_q, nbufrden_d;
    logic [9:0]  bufaddr_q, bufaddr_d;
    logic        ncs_q, ncs_d;
    logic        clk_q, clk_d;
    logic        mosi_q, mosi_d;

    logic [23:0] addr_s;
    logic [15:0] poll_inc_s;

    assign addr_s     = {2'b00, img_q, page_q, 7'b0000000};
    assign poll_inc_s = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : (poll_cnt_q + 16'd1);

    // Next-state logic: phase A drops CLK and presents a bit, phase B raises CLK and samples MISO.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        stat_d     = stat_q;
        sh_d       = sh_q;
        op_d       = op_q;
        img_d      = img_q;
        page_d     = page_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        nbufrden_d = nbufrden_q;
        bufaddr_d  = bufaddr_q;
        ncs_d      = ncs_q;
        clk_d      = clk_q;
        mosi_d     = mosi_q;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (START) begin
                    op_d      = OPTYPE;
                    img_d     = IMGNUM;
                    page_d    = OPTYPE ? (PAGE & 12'hFE0) : PAGE;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    ncs_d     = 1'b0;
                    sh_d      = {OP_WREN, 24'h000000};
                    bit_cnt_d = 10'd0;
                    phase_d   = 1'b0;
                    state_d   = S_WREN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WREN: begin
                if (!phase_q) begin
                    clk_d   = 1'b0;
                    mosi_d  = sh_q[31];
                    phase_d = 1'b1;
                end else begin
                    clk_d     = 1'b1;
                    sh_d      = {sh_q[30:0], 1'b0};
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 10'd1;
                    if (bit_cnt_q == 10'd7) begin
                        bit_cnt_d = 10'd0;
                        gap_cnt_d = 8'd0;
                        state_d   = S_GAP1;
                    end else begin
                        state_d = S_WREN;
                    end
                end
            end
            S_GAP1: begin
                ncs_d     = 1'b1;
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    ncs_d     = 1'b0;
                    sh_d      = {(op_q ? OP_SE : OP_PP), addr_s};
                    bit_cnt_d = 10'd0;
                    gap_cnt_d = 8'd0;
                    state_d   = S_CMD;
                end else begin
                    state_d = S_GAP1;
                end
            end
            S_CMD: begin
                if (!phase_q) begin
                    clk_d   = 1'b0;
                    mosi_d  = sh_q[31];
                    phase_d = 1'b1;
                    // Fetch buffer bit 0 two cycles ahead so it is ready for the first data bit.
                    if ((bit_cnt_q == 10'd31) && !op_q) begin
                        nbufrden_d = 1'b0;
                        bufaddr_d  = 10'd0;
                    end else begin
                        nbufrden_d = nbufrden_q;
                    end
                end else begin
                    clk_d     = 1'b1;
                    sh_d      = {sh_q[30:0], 1'b0};
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 10'd1;
                    if (bit_cnt_q == 10'd31) begin
                        bit_cnt_d = 10'd0;
                        state_d   = op_q ? S_END_CMD : S_DATA;
                    end else begin
                        state_d = S_CMD;
                    end
                end
            end
            S_DATA: begin
                if (!phase_q) begin
                    clk_d   = 1'b0;
                    mosi_d  = BUFRDDATA;
                    phase_d = 1'b1;
                    if (bit_cnt_q == 10'd1023) begin
                        nbufrden_d = 1'b1;
                    end else begin
                        bufaddr_d = bufaddr_q + 10'd1;
                    end
                end else begin
                    clk_d     = 1'b1;
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 10'd1;
                    if (bit_cnt_q == 10'd1023) begin
                        bit_cnt_d = 10'd0;
                        state_d   = S_END_CMD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_END_CMD: begin
                ncs_d     = 1'b1;
                gap_cnt_d = 8'd1;
                state_d   = S_GAP2;
            end
            S_GAP2: begin
                ncs_d     = 1'b1;
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    ncs_d      = 1'b0;
                    sh_d       = {OP_RDSR, 24'h000000};
                    bit_cnt_d  = 10'd0;
                    gap_cnt_d  = 8'd0;
                    stat_d     = 1'b0;
                    poll_cnt_d = 16'd0;
                    state_d    = S_RDSR;
                end else begin
                    state_d = S_GAP2;
                end
            end
            S_RDSR: begin
                if (!phase_q) begin
                    clk_d   = 1'b0;
                    mosi_d  = stat_q ? 1'b0 : sh_q[31];
                    phase_d = 1'b1;
                end else begin
                    clk_d     = 1'b1;
                    sh_d      = {sh_q[30:0], 1'b0};
                    phase_d   = 1'b0;
                    bit_cnt_d = bit_cnt_q + 10'd1;
                    if (bit_cnt_q == 10'd7) begin
                        bit_cnt_d = 10'd0;
                        stat_d    = 1'b1;
                        // MISO on the last bit of a status byte is the flash BUSY flag.
                        if (stat_q) begin
                            poll_cnt_d = poll_inc_s;
                            if (!MISO) begin
                                state_d = S_FINISH;
                            end else if (poll_inc_s == POLL_MAX) begin
                                err_d   = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                state_d = S_RDSR;
                            end
                        end else begin
                            state_d = S_RDSR;
                        end
                    end else begin
                        state_d = S_RDSR;
                    end
                end
            end
            S_FINISH: begin
                ncs_d      = 1'b1;
                clk_d      = 1'b1;
                mosi_d     = 1'b0;
                done_d     = 1'b1;
                nbufrden_d = 1'b1;
                bufaddr_d  = 10'd0;
                phase_d    = 1'b0;
                bit_cnt_d  = 10'd0;
                stat_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                ncs_d      = 1'b1;
                clk_d      = 1'b1;
                mosi_d     = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                nbufrden_d = 1'b1;
                bufaddr_d  = 10'd0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= 10'd0;
            gap_cnt_q  <= 8'd0;
            poll_cnt_q <= 16'd0;
            stat_q     <= 1'b0;
            sh_q       <= 32'd0;
            op_q       <= 1'b0;
            img_q      <= 3'd0;
            page_q     <= 12'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            nbufrden_q <= 1'b1;
            bufaddr_q  <= 10'd0;
            ncs_q      <= 1'b1;
            clk_q      <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            stat_q     <= stat_d;
            sh_q       <= sh_d;
            op_q       <= op_d;
            img_q      <= img_d;
            page_q     <= page_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            nbufrden_q <= nbufrden_d;
            bufaddr_q  <= bufaddr_d;
            ncs_q      <= ncs_d;
            clk_q      <= clk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign nBUFRDEN  = nbufrden_q;
    assign BUFRDADDR = bufaddr_q;
    assign nCS       = ncs_q;
    assign CLK       = clk_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_page_writer.sv
// Directed bench for spi_page_writer: bit-serial buffer model, W25Q32 SPI slave model
// with programmable status BUSY, and bus-timing monitors.
module tb_spi_page_writer;

    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        OPTYPE = 1'b0;
    logic [2:0]  IMGNUM = 3'd0;
    logic [11:0] PAGE = 12'd0;
    logic        BUSY, DONE, ERR, nBUFRDEN;
    logic [9:0]  BUFRDADDR;
    logic        BUFRDDATA = 1'b0;
    logic        nCS, CLK, MOSI;
    logic        MISO = 1'b0;

    int errors = 0;
    int checks = 0;

    logic mem [1024];
    int   busy_n = 0;
    bit   stuck = 1'b0;

    int          bitcnt = 0;
    logic [7:0]  shreg = 8'h00;
    logic [7:0]  cur_op = 8'h00;
    logic [7:0]  bytes_q[$];
    int          frames_q[$];
    int          cyc = 0;
    int          last_rise = 0;
    bit          rise_valid = 1'b0;
    int          clk_gap_err = 0, mosi_err = 0, csh_err = 0, rd_cnt = 0, done_cnt = 0;
    logic [9:0]  last_rd_addr = 10'd0;
    int          high_run = 0;
    bit          gap_valid = 1'b0;
    logic        prev_clk = 1'b1, prev_mosi = 1'b0, prev_ncs = 1'b1;

    spi_page_writer #(.CSH_CYCLES(4), .POLL_LIMIT(16)) dut (
        .MCLK(MCLK), .RST(RST), .START(START), .OPTYPE(OPTYPE), .IMGNUM(IMGNUM), .PAGE(PAGE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .nBUFRDEN(nBUFRDEN), .BUFRDADDR(BUFRDADDR),
        .BUFRDDATA(BUFRDDATA), .nCS(nCS), .CLK(CLK), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 MCLK = ~MCLK;

    // Page buffer: synchronous read, data appears the cycle after the enable.
    always @(posedge MCLK) if (nBUFRDEN === 1'b0) BUFRDDATA <= mem[BUFRDADDR];

    // Flash side: shift in MOSI on rising CLK, collect bytes and frame lengths.
    always @(posedge CLK) begin
        if (nCS === 1'b0) begin
            shreg = {shreg[6:0], MOSI};
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                bytes_q.push_back(shreg);
                if (bitcnt == 8) cur_op = shreg;
            end
        end
    end

    always @(posedge nCS) begin
        frames_q.push_back(bitcnt);
        bitcnt = 0;
        cur_op = 8'h00;
    end

    // Status register: bit0 set for the first busy_n status bytes (or forever when stuck).
    always @(negedge CLK) begin
        MISO = 1'b0;
        if (nCS === 1'b0 && cur_op == 8'h05 && bitcnt >= 8 && ((bitcnt - 8) % 8) == 7)
            MISO = stuck || (((bitcnt - 8) / 8) < busy_n);
    end

    // Bus timing monitors sampled mid-cycle.
    always @(negedge MCLK) begin
        cyc++;
        if (nCS !== 1'b0) rise_valid = 1'b0;
        if (nCS === 1'b0 && CLK === 1'b1 && prev_clk === 1'b0) begin
            if (rise_valid && (cyc - last_rise) != 2) clk_gap_err++;
            last_rise  = cyc;
            rise_valid = 1'b1;
        end
        if (nCS === 1'b0 && prev_ncs === 1'b0 && MOSI !== prev_mosi && CLK !== 1'b0) mosi_err++;
        if (prev_ncs === 1'b0 && nCS === 1'b1) begin
            high_run  = 0;
            gap_valid = (DONE !== 1'b1);
        end
        if (nCS === 1'b1) high_run++;
        if (prev_ncs === 1'b1 && nCS === 1'b0) begin
            if (gap_valid && high_run < 4) csh_err++;
            gap_valid = 1'b0;
        end
        if (nBUFRDEN === 1'b0) begin
            rd_cnt++;
            last_rd_addr = BUFRDADDR;
        end
        if (DONE === 1'b1) done_cnt++;
        prev_clk  = CLK;
        prev_mosi = MOSI;
        prev_ncs  = nCS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic start_op(input logic op, input logic [2:0] img, input logic [11:0] pg);
        START = 1'b1; OPTYPE = op; IMGNUM = img; PAGE = pg;
        @(negedge MCLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge MCLK);
        end
    endtask

    task automatic check_data(input string tag, input int base);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            e = (k % 2 == 0) ? 8'h5A : 8'hA5;
            if (bytes_q.size() <= base + k || bytes_q[base + k] !== e) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        bit ok;
        int b0, f0, d0, r0, c0;
        logic [7:0] pat;
        for (int n = 0; n < 1024; n++) begin
            pat = ((n / 8) % 2 == 0) ? 8'h5A : 8'hA5;
            mem[n] = pat[7 - (n % 8)];
        end

        // Reset, with a START that coincides with RST.
        tick(3);
        START = 1'b1;
        tick(1);
        START = 1'b0; RST = 1'b0;
        tick(1);
        chk("reset_outputs", {nCS, CLK, MOSI, BUSY, DONE, ERR, nBUFRDEN}, 7'b1100001);
        chk("reset_bufaddr", BUFRDADDR, 10'd0);
        tick(3);
        chk("start_with_rst_ignored", {BUSY, nCS}, 2'b01);

        // Program: image 3, page 0x805, flash busy for 3 status bytes.
        busy_n = 3; stuck = 1'b0;
        b0 = bytes_q.size(); f0 = frames_q.size(); d0 = done_cnt; c0 = csh_err;
        start_op(1'b0, 3'd3, 12'h805);
        chk("prog_busy_after_start", {BUSY, ERR}, 2'b10);
        wait_done(5000, ok);
        chk("prog_done_seen", ok, 1'b1);
        chk("prog_done_flags", {DONE, ERR, BUSY}, 3'b101);
        tick(1);
        chk("prog_after_done", {DONE, BUSY, BUFRDADDR}, 12'd0);
        chk("prog_frames", frames_q.size() - f0, 3);
        chk("prog_wren_bits", frames_q[f0], 8);
        chk("prog_cmd_data_bits", frames_q[f0 + 1], 1056);
        chk("prog_rdsr_bits", frames_q[f0 + 2], 8 + 8 * 4);
        chk("prog_wren_op", bytes_q[b0], 8'h06);
        chk("prog_opcode", bytes_q[b0 + 1], 8'h02);
        chk("prog_addr", {bytes_q[b0 + 2], bytes_q[b0 + 3], bytes_q[b0 + 4]}, 24'h1C0280);
        check_data("prog_data", b0 + 5);
        chk("prog_rdsr_op", bytes_q[b0 + 133], 8'h05);
        chk("prog_last_rd_addr", last_rd_addr, 10'd1023);
        chk("prog_csh_gaps", csh_err - c0, 0);
        chk("prog_done_pulses", done_cnt - d0, 1);

        // Erase: image 0, page 0x05F masked to 0x040, busy for 2 status bytes.
        busy_n = 2;
        b0 = bytes_q.size(); f0 = frames_q.size(); r0 = rd_cnt;
        start_op(1'b1, 3'd0, 12'h05F);
        wait_done(2000, ok);
        chk("erase_done_seen", ok, 1'b1);
        chk("erase_done_flags", {DONE, ERR}, 2'b10);
        tick(1);
        chk("erase_frames", {frames_q[f0], frames_q[f0 + 1], frames_q[f0 + 2]}, {32'd8, 32'd32, 32'd32});
        chk("erase_cmd", {bytes_q[b0 + 1], bytes_q[b0 + 2], bytes_q[b0 + 3], bytes_q[b0 + 4]}, 32'h20002000);
        chk("erase_no_buffer_reads", rd_cnt - r0, 0);

        // Timeout: status BUSY stuck, limit 16.
        stuck = 1'b1;
        f0 = frames_q.size();
        start_op(1'b1, 3'd1, 12'h020);
        wait_done(2000, ok);
        chk("timeout_done_seen", ok, 1'b1);
        chk("timeout_err_with_done", {DONE, ERR}, 2'b11);
        chk("timeout_status_bytes", frames_q[f0 + 2], 8 + 8 * 16);
        tick(5);
        chk("timeout_err_holds", {ERR, BUSY}, 2'b10);
        stuck = 1'b0; busy_n = 0;
        start_op(1'b1, 3'd1, 12'h020);
        chk("err_cleared_on_start", {ERR, BUSY}, 2'b01);
        wait_done(2000, ok);
        chk("clear_done", {ok, ERR}, 2'b10);
        tick(1);

        // START pulsed during DATA is ignored.
        busy_n = 1;
        b0 = bytes_q.size(); f0 = frames_q.size(); d0 = done_cnt;
        start_op(1'b0, 3'd2, 12'h010);
        for (int i = 0; i < 3000 && BUFRDADDR !== 10'd200; i++) @(negedge MCLK);
        chk("reached_data_200", BUFRDADDR, 10'd200);
        START = 1'b1; OPTYPE = 1'b1;
        tick(1);
        START = 1'b0; OPTYPE = 1'b0;
        wait_done(5000, ok);
        chk("midstart_done_seen", ok, 1'b1);
        tick(300);
        chk("midstart_single_done", done_cnt - d0, 1);
        chk("midstart_frames", frames_q.size() - f0, 3);
        chk("midstart_cmd", {bytes_q[b0 + 1], bytes_q[b0 + 2], bytes_q[b0 + 3], bytes_q[b0 + 4]}, 32'h02100800);
        chk("midstart_idle", BUSY, 1'b0);

        // RST at data bit 500, then a clean program.
        start_op(1'b0, 3'd4, 12'h0AA);
        for (int i = 0; i < 4000 && bitcnt != 532; i++) @(negedge MCLK);
        chk("reached_bit500", bitcnt, 532);
        RST = 1'b1;
        tick(1);
        chk("rst_mid_outputs", {nCS, CLK, MOSI, BUSY, nBUFRDEN}, 5'b11001);
        chk("rst_mid_bufaddr", BUFRDADDR, 10'd0);
        RST = 1'b0;
        tick(6);
        chk("rst_mid_quiet", {nCS, CLK, BUSY}, 3'b110);
        busy_n = 2;
        b0 = bytes_q.size(); f0 = frames_q.size(); d0 = done_cnt; c0 = csh_err;
        start_op(1'b0, 3'd5, 12'h123);
        wait_done(5000, ok);
        chk("rerun_done", {ok, DONE, ERR}, 3'b110);
        tick(1);
        chk("rerun_frames", {frames_q[f0], frames_q[f0 + 1], frames_q[f0 + 2]}, {32'd8, 32'd1056, 32'd32});
        chk("rerun_cmd", {bytes_q[b0], bytes_q[b0 + 1], bytes_q[b0 + 2], bytes_q[b0 + 3]}, 32'h06022891);
        chk("rerun_addr_lo", bytes_q[b0 + 4], 8'h80);
        check_data("rerun_data", b0 + 5);
        chk("rerun_last_rd_addr", last_rd_addr, 10'd1023);
        chk("rerun_csh_gaps", csh_err - c0, 0);

        // Clock integrity across everything above.
        chk("clk_period_2", clk_gap_err, 0);
        chk("mosi_stable_clk_high", mosi_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_page_writer.md
Name: spi_page_writer

Overview:
- Write-side counterpart of the SPI flash loader. Programs one 128-byte bubble page image (1024 bits) from a 1-bit-wide page buffer into the W25Q32, or erases one 4 KB sector.
- Every operation runs Write Enable (0x06), then Page Program (0x02) or Sector Erase (0x20), then Read Status Register-1 (0x05) polling until BUSY clears.
- Flash address layout is the loader's: {2'b00, IMGNUM[2:0], PAGE[11:0], 7'b0}. Written pages therefore read back unchanged through the existing loader.

Parameters:
- CSH_CYCLES, 4, MCLK cycles nCS is held high between commands (tSHSL ≥ 50 ns at 48 MHz).
- POLL_LIMIT, 65535, maximum status bytes read before declaring timeout (16-bit counter).

Ports:
- MCLK  in  1  48 MHz clock, all logic on posedge
- RST  in  1  synchronous active-high reset
- START  in  1  one-cycle request; sampled only in IDLE
- OPTYPE  in  1  0 = page program, 1 = sector erase
- IMGNUM  in  3  image number
- PAGE  in  12  page number; PAGE[4:0] forced to 0 for erase
- BUSY  out  1  high from the cycle after START is accepted until the DONE cycle inclusive
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  timeout flag; valid with DONE, holds until next accepted START
- nBUFRDEN  out  1  page buffer read clock enable, active low
- BUFRDADDR  out  10  page buffer bit address
- BUFRDDATA  in  1  buffer data, valid the MCLK after nBUFRDEN=0
- nCS, CLK, MOSI  out  1 each  SPI to W25Q32
- MISO  in  1  SPI from W25Q32

Behaviour:
- Reset values: nCS=1, CLK=1, MOSI=0, BUSY=0, DONE=0, ERR=0, nBUFRDEN=1, BUFRDADDR=0; state IDLE, all counters 0.
- RST mid-operation: same values on the next edge, no trailing SPI clocks. An erase or program already started in the flash is left to finish; the next START's status poll absorbs it.
- SPI mode 3; CLK idles high.
- Each bit takes 2 MCLK: phase A drives CLK<=0 and MOSI<=bit; phase B drives CLK<=1 and samples MISO in the same cycle.
- Bytes are sent MSB first. CLK period is exactly 2 MCLK, with no stretching, from the first command bit through the last data bit.
- The buffer must be prefetched so that buffer bit n is on MOSI for data bit n (n = 0..1023).
- START handling:
  - Accepted in IDLE only: latches OPTYPE, IMGNUM, PAGE; clears ERR.
  - START in any other state is ignored.
  - START coincident with RST is ignored.
- States and transitions:
  - IDLE -> WREN: nCS<=0, 8 bits of 0x06 -> nCS<=1.
  - GAP1: CSH_CYCLES cycles.
  - CMD: nCS<=0, 8-bit opcode (0x02 or 0x20) then 24-bit address.
  - DATA (program only): 1024 bits from the buffer.
  - END_CMD: nCS<=1.
  - GAP2: CSH_CYCLES cycles.
  - RDSR: nCS<=0, 8 bits of 0x05, then repeated 8-bit status reads with nCS held low and MOSI=0.
    - After each status byte the poll counter increments.
    - Bit0 (BUSY) = 0 -> FINISH.
    - Bit0 = 1 and counter == POLL_LIMIT -> FINISH with ERR<=1.
    - Otherwise read another byte.
  - FINISH: nCS<=1, CLK<=1, DONE<=1 for 1 cycle, BUSY<=0 the following cycle -> IDLE.
- SPI clock counts per operation:
  - WREN: 8 clocks.
  - Program CMD+DATA: 1056 clocks.
  - Erase CMD: 32 clocks.
  - RDSR: 8 + 8·k clocks, k = status bytes read.
- Buffer read rules:
  - nBUFRDEN low only during DATA prefetch.
  - BUFRDADDR increments 0..1023 with no wrap within an operation, and returns to 0 at FINISH.
  - Never more than 1023 and never read outside DATA.
- The status counter is 16-bit and saturates; it cannot wrap.

Test Plan:
- Program, OPTYPE=0, IMGNUM=3, PAGE=0x805, buffer = alternating 0x5A/0xA5, flash model BUSY for 3 status bytes:
  - MOSI bytes are 0x06 | 0x02 1C 02 80 + 128 data bytes | 0x05.
  - Exactly 4 status bytes read; DONE=1, ERR=0.
  - nCS high ≥ 4 MCLK between commands.
- Erase, OPTYPE=1, IMGNUM=0, PAGE=0x05F:
  - Address sent is 0x002000 (PAGE[4:0] masked); 32 CMD clocks.
  - No nBUFRDEN activity.
  - DONE after BUSY clears.
- Timeout, POLL_LIMIT=16, flash BUSY stuck at 1:
  - Exactly 16 status bytes read; ERR=1 with the DONE pulse.
  - Next START clears ERR the cycle after acceptance.
- START pulsed during DATA phase:
  - Ignored; only one operation completes and only one DONE pulse occurs.
- RST asserted at data bit 500:
  - Next edge gives nCS=1, CLK=1, MOSI=0, BUSY=0, BUFRDADDR=0.
  - A following START runs a complete, correct program sequence.
- Clock integrity over a full program:
  - CLK toggles every MCLK during CMD+DATA (1056 continuous periods).
  - MOSI stable whenever CLK=1.
